// File: rtl/fwd_pkg.sv
// Shared types for the EX-stage operand forwarding scheduler: source codes,
// in-flight slot record and the register-hit test.
package fwd_pkg;
  localparam int RA_W  = 5;
  localparam int SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    SRC_RF        = 3'd0,
    SRC_EXMEM_ALU = 3'd1,
    SRC_MEMWB_ALU = 3'd2,
    SRC_MEMWB_LD  = 3'd3,
    SRC_ALT       = 3'd4
  } fwd_src_e;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            wen;
    logic            load;
  } slot_t;

  // x0 never hits because wen is masked at slot entry and rs==0 is rejected here too.
  function automatic logic slot_hit(slot_t s, logic en, logic [RA_W-1:0] rs);
    return en && (rs != '0) && s.valid && s.wen && (s.rd == rs);
  endfunction
endpackage

// File: rtl/fwd_src_pick.sv
// Per-operand source select: alternate source, else youngest matching producer.
module fwd_src_pick
  import fwd_pkg::*;
(
  input  logic [RA_W-1:0]  rs,
  input  logic             rs_use,
  input  logic             alt,
  input  slot_t            e,
  input  slot_t            m,
  output logic [SEL_W-1:0] sel
);
  always_comb begin
    sel = SRC_RF;
    if (alt)                     sel = SRC_ALT;
    else if (slot_hit(e, rs_use, rs)) sel = SRC_EXMEM_ALU;
    else if (slot_hit(m, rs_use, rs)) sel = m.load ? SRC_MEMWB_LD : SRC_MEMWB_ALU;
  end
endmodule

// File: rtl/fwd_sched.sv
// Operand-source scheduler: tracks EX/MEM/WB destinations, registers the
// ALU A/B mux selects and raises a one-cycle load-use stall.
module fwd_sched
  import fwd_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             id_a_pc,
  input  logic             id_b_imm,
  output logic             stall,
  output logic [SEL_W-1:0] sel_a,
  output logic [SEL_W-1:0] sel_b,
  output logic             ex_valid
);
  slot_t            e_q;
  slot_t            mw_q [DEPTH];  // [0] = MEM, [DEPTH-1] = WB (WB kept for observability)
  logic [SEL_W-1:0] pick_a, pick_b;
  logic             issue;

  fwd_src_pick u_pick_a (
    .rs(id_rs1), .rs_use(id_use_rs1), .alt(id_a_pc), .e(e_q), .m(mw_q[0]), .sel(pick_a)
  );
  fwd_src_pick u_pick_b (
    .rs(id_rs2), .rs_use(id_use_rs2), .alt(id_b_imm), .e(e_q), .m(mw_q[0]), .sel(pick_b)
  );

  assign stall = id_valid & e_q.load &
                 (slot_hit(e_q, id_use_rs1, id_rs1) | slot_hit(e_q, id_use_rs2, id_rs2));
  assign issue = id_valid & ~flush & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q      <= '0;
      for (int i = 0; i < DEPTH; i++) mw_q[i] <= '0;
      sel_a    <= '0;
      sel_b    <= '0;
      ex_valid <= 1'b0;
    end else if (!hold) begin
      for (int i = DEPTH - 1; i > 0; i--) mw_q[i] <= mw_q[i-1];
      mw_q[0] <= e_q;
      if (issue) begin
        e_q.valid <= 1'b1;
        e_q.rd    <= id_rd;
        e_q.wen   <= id_reg_write & (id_rd != '0);
        e_q.load  <= id_is_load;
        sel_a     <= pick_a;
        sel_b     <= pick_b;
        ex_valid  <= 1'b1;
      end else begin
        e_q      <= '0;
        sel_a    <= '0;
        sel_b    <= '0;
        ex_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fwd_sched.sv
// Directed bench for fwd_sched: forwarding selects, load-use stall, hold, flush, reset.
module tb_fwd_sched;
  logic       clk = 1'b0;
  logic       rst, hold, flush, id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_reg_write, id_is_load, id_a_pc, id_b_imm;
  logic       stall, ex_valid;
  logic [2:0] sel_a, sel_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fwd_sched dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_a_pc(id_a_pc), .id_b_imm(id_b_imm),
    .stall(stall), .sel_a(sel_a), .sel_b(sel_b), .ex_valid(ex_valid)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // rs1/rs2 of 0 mean "not used"; rd of 0 with wen still exercises the x0 mask.
  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic wen, input logic ld,
                        input logic apc, input logic bimm, input logic use1, input logic use2);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_reg_write = wen; id_is_load = ld; id_a_pc = apc; id_b_imm = bimm;
    id_use_rs1 = use1; id_use_rs2 = use2;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] a, input logic [2:0] b,
                         input logic v);
    chk({tag, ".sel_a"}, 8'(sel_a), 8'(a));
    chk({tag, ".sel_b"}, 8'(sel_b), 8'(b));
    chk({tag, ".ex_valid"}, 8'(ex_valid), 8'(v));
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    idle();
    tick(); tick();
    chk_out("reset", 3'd0, 3'd0, 1'b0);
    chk("reset.stall", 8'(stall), 8'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("idle", 3'd0, 3'd0, 1'b0);
      chk("idle.stall", 8'(stall), 8'd0);
    end

    // ADD x5 then SUB x8, x5, x6: EX forward on A
    set_id(1, 5'd1, 5'd2, 5'd5, 1, 0, 0, 0, 1, 1); tick();
    chk_out("add_x5", 3'd0, 3'd0, 1'b1);
    set_id(1, 5'd5, 5'd6, 5'd8, 1, 0, 0, 0, 1, 1);
    chk("sub.stall", 8'(stall), 8'd0);
    tick();
    chk_out("sub", 3'd1, 3'd0, 1'b1);
    idle(); tick(); tick();

    // LW x7 then ADD x9, x1, x7: one stall cycle, bubble, then load-data select
    set_id(1, 5'd1, 5'd0, 5'd7, 1, 1, 0, 0, 1, 0); tick();
    set_id(1, 5'd1, 5'd7, 5'd9, 1, 0, 0, 0, 1, 1);
    chk("lu.stall", 8'(stall), 8'd1);
    tick();
    chk_out("lu.bubble", 3'd0, 3'd0, 1'b0);
    chk("lu.stall_drop", 8'(stall), 8'd0);
    tick();
    chk_out("lu.issue", 3'd0, 3'd3, 1'b1);
    idle(); tick(); tick();

    // ADD x3 ; ADD x3 ; consumer rs1=x3 -> youngest (EX) wins
    set_id(1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 1, 1); tick();
    set_id(1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 1, 1); tick();
    set_id(1, 5'd3, 5'd4, 5'd10, 1, 0, 0, 0, 1, 1); tick();
    chk_out("youngest", 3'd1, 3'd0, 1'b1);
    // x3 now only in MEM (ALU) -> select 2 on B
    set_id(1, 5'd4, 5'd3, 5'd12, 1, 0, 0, 0, 1, 1); tick();
    chk_out("mem_alu", 3'd0, 3'd2, 1'b1);
    idle(); tick(); tick();

    // producer targets x0; consumer reading x0 must not forward
    set_id(1, 5'd1, 5'd2, 5'd0, 1, 0, 0, 0, 1, 1); tick();
    set_id(1, 5'd0, 5'd0, 5'd11, 1, 0, 0, 0, 1, 1); tick();
    chk_out("x0", 3'd0, 3'd0, 1'b1);
    // B immediate overrides an EX match on rs2; A still forwards
    set_id(1, 5'd11, 5'd11, 5'd13, 1, 0, 0, 1, 1, 1); tick();
    chk_out("alt_b", 3'd1, 3'd4, 1'b1);
    idle(); tick(); tick();

    // stall held for 4 cycles under hold: everything frozen
    set_id(1, 5'd1, 5'd0, 5'd7, 1, 1, 0, 0, 1, 0); tick();
    chk_out("hold.lw", 3'd0, 3'd0, 1'b1);
    set_id(1, 5'd7, 5'd2, 5'd9, 1, 0, 0, 0, 1, 1);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("hold", 3'd0, 3'd0, 1'b1);
      chk("hold.stall", 8'(stall), 8'd1);
    end
    hold = 1'b0; tick();
    chk_out("hold.release", 3'd0, 3'd0, 1'b0);
    chk("hold.release_stall", 8'(stall), 8'd0);

    // flush kills the valid instruction entering EX
    flush = 1'b1; tick(); flush = 1'b0;
    chk_out("flush", 3'd0, 3'd0, 1'b0);

    // flush and stall together: bubble, stall still asserted combinationally
    set_id(1, 5'd1, 5'd0, 5'd7, 1, 1, 0, 0, 1, 0); tick();
    set_id(1, 5'd7, 5'd2, 5'd9, 1, 0, 0, 0, 1, 1);
    flush = 1'b1;
    chk("flush_stall.stall", 8'(stall), 8'd1);
    tick(); flush = 1'b0;
    chk_out("flush_stall", 3'd0, 3'd0, 1'b0);

    // mid-stream reset with hold asserted clears slots and outputs
    set_id(1, 5'd1, 5'd2, 5'd14, 1, 0, 0, 0, 1, 1); tick();
    set_id(1, 5'd14, 5'd2, 5'd15, 1, 0, 0, 0, 1, 1); tick();
    chk_out("pre_rst", 3'd1, 3'd0, 1'b1);
    rst = 1'b1; hold = 1'b1; tick();
    chk_out("mid_rst", 3'd0, 3'd0, 1'b0);
    rst = 1'b0; hold = 1'b0;
    set_id(1, 5'd15, 5'd14, 5'd16, 1, 0, 0, 0, 1, 1); tick();
    chk_out("post_rst", 3'd0, 3'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fwd_sched.md
Name: fwd_sched

Overview:
- Operand-source scheduler for the EX-stage 5:1 operand muxes (ALU A and ALU B) of the 5-stage RISC-V pipeline.
- Tracks the destination registers of the in-flight instructions in EX, MEM and WB.
- Produces a registered 3-bit select per operand for the instruction entering EX.
- Detects load-use hazards, requests a one-cycle ID stall, and inserts a bubble.

Parameters:
- RA_W, 5, register address width.
- SEL_W, 3, mux select width (5 sources).
- DEPTH, 2, number of tracked producer stages beyond EX (MEM, WB); fixed at 2 in this revision.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- hold  in  1  global freeze (memory wait); all state holds.
- flush  in  1  taken branch/jump; kill the instruction entering EX.
- id_valid  in  1  a valid instruction is in ID.
- id_rs1  in  RA_W  source register 1.
- id_rs2  in  RA_W  source register 2.
- id_rd  in  RA_W  destination register.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- id_reg_write  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- id_a_pc  in  1  operand A is the PC.
- id_b_imm  in  1  operand B is the immediate.
- stall  out  1  combinational ID/IF stall request.
- sel_a  out  SEL_W  registered select for the operand-A mux.
- sel_b  out  SEL_W  registered select for the operand-B mux.
- ex_valid  out  1  the EX slot holds a real instruction (not a bubble).

Behaviour:
- Select encoding, in package fwd_pkg:
  - 0 = SRC_RF: register file.
  - 1 = SRC_EXMEM_ALU: EX/MEM ALU result.
  - 2 = SRC_MEMWB_ALU: MEM/WB ALU result.
  - 3 = SRC_MEMWB_LD: MEM/WB load data.
  - 4 = SRC_ALT: PC for A, immediate for B.
  - Values 5-7 are never driven.
- State: three slot records E (EX), M (MEM), W (WB), each {valid, rd, wen, load}.
- Reset: all slots invalid. sel_a = sel_b = 0, ex_valid = 0. stall depends only on slots, so it is 0.
- Hazard definition: an operand hits slot S when all of the following hold:
  - its use bit is set;
  - its register is non-zero;
  - S.valid, S.wen, and S.rd equals that register.
- stall = id_valid & E.load & (rs1 hits E | rs2 hits E). Combinational, same cycle. Independent of hold.
- Per clock edge when hold = 1: nothing changes, including sel_a, sel_b and ex_valid.
- Per clock edge when hold = 0:
  - W <= M, M <= E.
  - E loads as follows:
    - If flush, or stall, or ~id_valid: E <= bubble (valid 0). sel_a, sel_b <= 0. ex_valid <= 0.
    - Otherwise: E <= {1, id_rd, id_reg_write & id_rd != 0, id_is_load}, and ex_valid <= 1.
  - sel_a when E loads a real instruction, computed against pre-edge E and M:
    - id_a_pc -> 4;
    - else rs1 hits E -> 1 (never a load here; the stall guarantees it);
    - else rs1 hits M -> M.load ? 3 : 2;
    - else 0.
  - sel_b: identical rule using id_rs2 and id_b_imm.
- Priority: the youngest producer wins. E beats M when both match.
- x0 is never forwarded. sel is 0 for rs = 0 even if a slot claims rd = 0, because wen is masked at entry.
- Simultaneous flush and stall: flush dominates; a bubble is inserted. The stall output still follows its equation.
- Latency: a stall lasts exactly 1 cycle per load-use pair. The next cycle E is a bubble, the load is in M, and the dependent instruction issues with select 3.
- Reset mid-operation: all slots are cleared on the next edge regardless of hold or flush.
- W is retained for observability only. Register-file write-before-read is handled by the register file, so W never generates a select.

Decomposition:
- fwd_pkg:
  - fwd_src_e enum (the 5 source codes);
  - slot_t struct {valid, rd, wen, load};
  - RA_W and SEL_W constants.
- One sub-module, fwd_src_pick: combinational per-operand select from (rs, use, alt, E, M). Instantiated twice.
- Slot registers and the stall logic live in fwd_sched.

Test Plan:
- Reset, then idle -> sel_a = sel_b = 0, stall = 0, ex_valid = 0 for 3 cycles.
- ADD x5 in EX, then SUB rs1 = x5 rs2 = x6 issues -> sel_a = 1, sel_b = 0, no stall.
- LW x7 in EX, then ADD rs2 = x7 in ID -> stall = 1 for one cycle, bubble (ex_valid = 0). Next edge: sel_b = 3, stall = 0.
- ADD x3 followed by ADD x3, then consumer rs1 = x3 -> sel_a = 1 (youngest wins over M's 2).
- Consumer rs1 = x0, with a producer that targeted x0 in EX -> sel_a = 0. Consumer id_b_imm = 1 with rs2 matching E -> sel_b = 4.
- Stall condition present with hold = 1 for 4 cycles -> outputs and slots frozen. flush with a valid ID -> ex_valid = 0 next edge. rst asserted mid-stream -> all outputs 0 next edge.
